rle_enc: RTL and testbench

RLE_ENC -- requirements
Module: rle_enc

---
 rtl/rle_enc.sv | 196 +++++++++++++++++++
 tb/tb_rle_enc.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_enc.sv
// Run-length encoder for 8/16/32-bit sample streams.
// Flag-bit value/count words, one pending slot, flush-then-queue on exit.
module rle_enc #(
  parameter int DW = 32,
  parameter int KW = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          arm,
  input  logic [1:0]    rle_mode,
  input  logic [KW-1:0] disabledGroups,
  input  logic [DW-1:0] sti_data,
  input  logic          sti_valid,
  output logic [DW-1:0] sto_data,
  output logic          sto_valid
);

  localparam logic [KW-1:0] G8  = ~KW'(1);
  localparam logic [KW-1:0] G16 = ~KW'(3);

  typedef enum logic [1:0] {
    ST_PASS,
    ST_ENC,
    ST_FLUSH
  } state_t;

  state_t        state_q, state_d;
  logic          sv_q, sv_d;
  logic [DW-1:0] val_q, val_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          reemit_q, reemit_d;
  logic          pend_v_q, pend_v_d;
  logic [DW-1:0] pend_q, pend_d;
  logic [DW-1:0] q0_q, q0_d;
  logic [DW-1:0] q1_q, q1_d;
  logic [1:0]    qn_q, qn_d;

  logic          enc;
  logic [DW-1:0] pmask;
  logic [DW-1:0] flag;
  logic [DW-1:0] pay;
  logic [DW-1:0] cword;
  logic [DW-1:0] eword;
  logic          flush_need;
  logic          do_enc;
  logic          do_flush;
  logic          o_v;
  logic [DW-1:0] o_d;

  always_comb begin
    unique case (1'b1)
      (disabledGroups == G8):  pmask = {DW{1'b1}} >> (DW - 7);
      (disabledGroups == G16): pmask = {DW{1'b1}} >> (DW - 15);
      default:                 pmask = {DW{1'b1}} >> 1;
    endcase
    flag  = pmask + DW'(1);
    pay   = sti_data & pmask;
    cword = flag | cnt_q;
    // a run of exactly one repeat may be sent as a second value word
    eword = (rle_mode[0] && cnt_q == DW'(1)) ? val_q : cword;

    enc        = enable & arm;
    flush_need = pend_v_q || (sv_q && cnt_q != '0);
    do_enc     = enc && (state_q == ST_ENC ||
                 (state_q == ST_PASS && qn_q == 2'd0));
    do_flush   = !do_enc && (state_q == ST_FLUSH ||
                 (state_q == ST_ENC && flush_need));

    state_d  = state_q;
    sv_d     = sv_q;
    val_d    = val_q;
    cnt_d    = cnt_q;
    reemit_d = reemit_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    q0_d     = q0_q;
    q1_d     = q1_q;
    qn_d     = qn_q;
    o_v      = 1'b0;
    o_d      = '0;

    if (do_enc) begin
      state_d = ST_ENC;
      if (pend_v_q) begin
        o_v      = 1'b1;
        o_d      = pend_q;
        pend_v_d = 1'b0;
      end
      if (sti_valid) begin
        if (!sv_q || pay != val_q) begin
          sv_d     = 1'b1;
          val_d    = pay;
          cnt_d    = '0;
          reemit_d = 1'b0;
          if (sv_q && cnt_q != '0) begin
            o_v      = 1'b1;
            o_d      = eword;
            pend_v_d = 1'b1;
            pend_d   = pay;
          end else if (pend_v_q) begin
            pend_v_d = 1'b1;
            pend_d   = pay;
          end else begin
            o_v = 1'b1;
            o_d = pay;
          end
        end else if (cnt_q + DW'(1) == pmask) begin
          o_v      = 1'b1;
          o_d      = flag | pmask;
          cnt_d    = '0;
          reemit_d = rle_mode[1];
        end else begin
          cnt_d = cnt_q + DW'(1);
          // output slot is free on a repeat, so re-send the value now
          if (reemit_q && cnt_q == '0) begin
            o_v      = 1'b1;
            o_d      = val_q;
            reemit_d = 1'b0;
          end
        end
      end
    end else if (do_flush) begin
      o_v = 1'b1;
      if (pend_v_q) begin
        o_d      = pend_q;
        pend_v_d = 1'b0;
      end else begin
        o_d   = eword;
        cnt_d = '0;
      end
      state_d = (pend_v_q && cnt_q != '0) ? ST_FLUSH : ST_PASS;
      if (state_d == ST_PASS) begin
        sv_d     = 1'b0;
        cnt_d    = '0;
        reemit_d = 1'b0;
      end
      if (sti_valid) begin
        if (qn_d == 2'd0) q0_d = sti_data;
        else              q1_d = sti_data;
        qn_d = qn_d + 2'd1;
      end
    end else begin
      state_d  = ST_PASS;
      sv_d     = 1'b0;
      cnt_d    = '0;
      reemit_d = 1'b0;
      pend_v_d = 1'b0;
      if (qn_q != 2'd0) begin
        o_v  = 1'b1;
        o_d  = q0_q;
        q0_d = q1_q;
        qn_d = qn_q - 2'd1;
        if (sti_valid) begin
          if (qn_d == 2'd0) q0_d = sti_data;
          else              q1_d = sti_data;
          qn_d = qn_d + 2'd1;
        end
      end else begin
        o_v = sti_valid;
        o_d = sti_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PASS;
      sv_q      <= 1'b0;
      val_q     <= '0;
      cnt_q     <= '0;
      reemit_q  <= 1'b0;
      pend_v_q  <= 1'b0;
      pend_q    <= '0;
      q0_q      <= '0;
      q1_q      <= '0;
      qn_q      <= 2'd0;
      sto_data  <= '0;
      sto_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      sv_q      <= sv_d;
      val_q     <= val_d;
      cnt_q     <= cnt_d;
      reemit_q  <= reemit_d;
      pend_v_q  <= pend_v_d;
      pend_q    <= pend_d;
      q0_q      <= q0_d;
      q1_q      <= q1_d;
      qn_q      <= qn_d;
      sto_data  <= o_d;
      sto_valid <= o_v;
    end
  end

endmodule

// File: tb/tb_rle_enc.sv
// Directed bench for rle_enc: pass-through, runs, saturation,
// mode options, pending deferral, flush and async reset.
module tb_rle_enc;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        arm;
  logic [1:0]  rle_mode;
  logic [3:0]  disabledGroups;
  logic [31:0] sti_data;
  logic        sti_valid;
  logic [31:0] sto_data;
  logic        sto_valid;

  int checks;
  int failures;
  logic [31:0] got[$];

  rle_enc dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .arm            (arm),
    .rle_mode       (rle_mode),
    .disabledGroups (disabledGroups),
    .sti_data       (sti_data),
    .sti_valid      (sti_valid),
    .sto_data       (sto_data),
    .sto_valid      (sto_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (sto_valid) got.push_back(sto_data);

  task automatic step(input logic v, input logic [31:0] d);
    sti_valid = v;
    sti_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++;
    if (sto_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", sto_valid);
    end
    checks++;
    if (sto_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", sto_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_passthrough;
    disabledGroups = 4'b1110;
    enable = 1'b0;
    arm    = 1'b1;
    step(1'b1, 32'h41414141);
    checks++;
    if (sto_valid !== 1'b1 || sto_data !== 32'h41414141) begin
      failures++;
      $display("FAIL pass_word got=%b/%h exp=1/41414141",
               sto_valid, sto_data);
    end
    step(1'b0, 32'h42424242);
    checks++;
    if (sto_valid !== 1'b0) begin
      failures++;
      $display("FAIL pass_invalid got=%b exp=0", sto_valid);
    end
    enable = 1'b1;
    arm    = 1'b0;
    step(1'b1, 32'h11223344);
    checks++;
    if (sto_valid !== 1'b1 || sto_data !== 32'h11223344) begin
      failures++;
      $display("FAIL pass_disarmed got=%b/%h exp=1/11223344",
               sto_valid, sto_data);
    end
    enable = 1'b0;
    arm    = 1'b1;
    idle(2);
  endtask

  task automatic test_basic;
    logic [31:0] want[$];
    logic [31:0] g;
    want = '{32'h44, 32'h82, 32'h45};
    disabledGroups = 4'b1110;
    rle_mode = 2'b00;
    enable = 1'b1;
    got.delete();
    step(1'b1, 32'h44);
    checks++;
    if (sto_valid !== 1'b1 || sto_data !== 32'h44) begin
      failures++;
      $display("FAIL basic_latency got=%b/%h exp=1/44",
               sto_valid, sto_data);
    end
    step(1'b1, 32'h44);
    step(1'b1, 32'h44);
    step(1'b1, 32'h45);
    idle(4);
    checks++;
    if (got.size() != want.size()) begin
      failures++;
      $display("FAIL basic_len got=%0d exp=%0d", got.size(), want.size());
    end
    foreach (want[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      checks++;
      if (g !== want[i]) begin
        failures++;
        $display("FAIL basic_w%0d got=%h exp=%h", i, g, want[i]);
      end
    end
    enable = 1'b0;
    idle(2);
  endtask

  task automatic test_saturate;
    logic [31:0] want[$];
    logic [31:0] g;
    want = '{32'h4B, 32'hFF, 32'h81, 32'h4C};
    disabledGroups = 4'b1110;
    rle_mode = 2'b00;
    enable = 1'b1;
    got.delete();
    for (int i = 0; i < 129; i++) step(1'b1, 32'h4B);
    step(1'b1, 32'h4C);
    idle(4);
    checks++;
    if (got.size() != want.size()) begin
      failures++;
      $display("FAIL sat_len got=%0d exp=%0d", got.size(), want.size());
    end
    foreach (want[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      checks++;
      if (g !== want[i]) begin
        failures++;
        $display("FAIL sat_w%0d got=%h exp=%h", i, g, want[i]);
      end
    end
    enable = 1'b0;
    idle(2);
  endtask

  task automatic test_gaps;
    logic [31:0] want[$];
    logic [31:0] g;
    want = '{32'h43, 32'h81, 32'h44};
    disabledGroups = 4'b1110;
    rle_mode = 2'b00;
    enable = 1'b1;
    got.delete();
    step(1'b1, 32'h43);
    step(1'b0, 32'h99);
    step(1'b0, 32'h43);
    step(1'b1, 32'h43);
    step(1'b1, 32'h44);
    idle(4);
    checks++;
    if (got.size() != want.size()) begin
      failures++;
      $display("FAIL gaps_len got=%0d exp=%0d", got.size(), want.size());
    end
    foreach (want[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      checks++;
      if (g !== want[i]) begin
        failures++;
        $display("FAIL gaps_w%0d got=%h exp=%h", i, g, want[i]);
      end
    end
    enable = 1'b0;
    idle(2);
  endtask

  task automatic test_mode_single;
    logic [31:0] want[$];
    logic [31:0] g;
    want = '{32'h10, 32'h10, 32'h11};
    disabledGroups = 4'b1110;
    rle_mode = 2'b01;
    enable = 1'b1;
    got.delete();
    step(1'b1, 32'h10);
    step(1'b1, 32'h10);
    step(1'b1, 32'h11);
    idle(4);
    checks++;
    if (got.size() != want.size()) begin
      failures++;
      $display("FAIL single_len got=%0d exp=%0d", got.size(), want.size());
    end
    foreach (want[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      checks++;
      if (g !== want[i]) begin
        failures++;
        $display("FAIL single_w%0d got=%h exp=%h", i, g, want[i]);
      end
    end
    enable = 1'b0;
    rle_mode = 2'b00;
    idle(2);
  endtask

  task automatic test_reemit;
    logic [31:0] want[$];
    logic [31:0] g;
    want = '{32'h20, 32'hFF, 32'h20, 32'h81, 32'h21};
    disabledGroups = 4'b1110;
    rle_mode = 2'b10;
    enable = 1'b1;
    got.delete();
    for (int i = 0; i < 129; i++) step(1'b1, 32'h20);
    step(1'b1, 32'h21);
    idle(4);
    checks++;
    if (got.size() != want.size()) begin
      failures++;
      $display("FAIL reemit_len got=%0d exp=%0d", got.size(), want.size());
    end
    foreach (want[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      checks++;
      if (g !== want[i]) begin
        failures++;
        $display("FAIL reemit_w%0d got=%h exp=%h", i, g, want[i]);
      end
    end
    enable = 1'b0;
    rle_mode = 2'b00;
    idle(2);
  endtask

  task automatic test_back_to_back;
    logic [31:0] want[$];
    logic [31:0] g;
    want = '{32'h01, 32'h81, 32'h02, 32'h03, 32'h04};
    disabledGroups = 4'b1110;
    rle_mode = 2'b00;
    enable = 1'b1;
    got.delete();
    step(1'b1, 32'h01);
    step(1'b1, 32'h01);
    step(1'b1, 32'h02);
    step(1'b1, 32'h03);
    step(1'b1, 32'h04);
    idle(4);
    checks++;
    if (got.size() != want.size()) begin
      failures++;
      $display("FAIL b2b_len got=%0d exp=%0d", got.size(), want.size());
    end
    foreach (want[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      checks++;
      if (g !== want[i]) begin
        failures++;
        $display("FAIL b2b_w%0d got=%h exp=%h", i, g, want[i]);
      end
    end
    enable = 1'b0;
    idle(2);
  endtask

  task automatic test_flush32;
    logic [31:0] want[$];
    logic [31:0] g;
    want = '{32'h12345678, 32'h80000004, 32'hAAAA0001, 32'hAAAA0002};
    disabledGroups = 4'b0000;
    rle_mode = 2'b00;
    enable = 1'b1;
    got.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 32'h12345678);
    enable = 1'b0;
    step(1'b1, 32'hAAAA0001);
    step(1'b1, 32'hAAAA0002);
    idle(4);
    checks++;
    if (got.size() != want.size()) begin
      failures++;
      $display("FAIL flush32_len got=%0d exp=%0d", got.size(), want.size());
    end
    foreach (want[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      checks++;
      if (g !== want[i]) begin
        failures++;
        $display("FAIL flush32_w%0d got=%h exp=%h", i, g, want[i]);
      end
    end
    idle(2);
  endtask

  task automatic test_flush_pending;
    logic [31:0] want[$];
    logic [31:0] g;
    want = '{32'h05, 32'h81, 32'h06, 32'h77, 32'h78};
    disabledGroups = 4'b1110;
    rle_mode = 2'b00;
    enable = 1'b1;
    got.delete();
    step(1'b1, 32'h05);
    step(1'b1, 32'h05);
    step(1'b1, 32'h06);
    enable = 1'b0;
    step(1'b1, 32'h77);
    step(1'b1, 32'h78);
    idle(4);
    checks++;
    if (got.size() != want.size()) begin
      failures++;
      $display("FAIL fpend_len got=%0d exp=%0d", got.size(), want.size());
    end
    foreach (want[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      checks++;
      if (g !== want[i]) begin
        failures++;
        $display("FAIL fpend_w%0d got=%h exp=%h", i, g, want[i]);
      end
    end
    idle(2);
  endtask

  task automatic test_reset_midrun;
    logic [31:0] want[$];
    logic [31:0] g;
    want = '{32'h55};
    disabledGroups = 4'b1110;
    rle_mode = 2'b00;
    enable = 1'b1;
    step(1'b1, 32'h30);
    step(1'b1, 32'h30);
    step(1'b1, 32'h31);
    checks++;
    if (sto_valid !== 1'b1 || sto_data !== 32'h81) begin
      failures++;
      $display("FAIL rst_pre got=%b/%h exp=1/81", sto_valid, sto_data);
    end
    sti_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sto_valid !== 1'b0 || sto_data !== 32'h0) begin
      failures++;
      $display("FAIL rst_async got=%b/%h exp=0/0", sto_valid, sto_data);
    end
    got.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(1);
    step(1'b1, 32'h55);
    idle(4);
    checks++;
    if (got.size() != want.size()) begin
      failures++;
      $display("FAIL rst_len got=%0d exp=%0d", got.size(), want.size());
    end
    foreach (want[i]) begin
      g = (i < got.size()) ? got[i] : 'x;
      checks++;
      if (g !== want[i]) begin
        failures++;
        $display("FAIL rst_w%0d got=%h exp=%h", i, g, want[i]);
      end
    end
    enable = 1'b0;
    idle(2);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b1;
    enable         = 1'b0;
    arm            = 1'b1;
    rle_mode       = 2'b00;
    disabledGroups = 4'b1110;
    sti_data       = 32'h0;
    sti_valid      = 1'b0;
    #1;
    test_reset;
    test_passthrough;
    test_basic;
    test_saturate;
    test_gaps;
    test_mode_single;
    test_reemit;
    test_back_to_back;
    test_flush32;
    test_flush_pending;
    test_reset_midrun;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
